// File: rtl/pipeline_ctrl.sv
// MiniMIPS32 pipeline sequencing: merges stall requests, divide wait and MEM exceptions.
// Define DIV_HANDSHAKE_EN to end divides on div_ready instead of the fixed DIV_CYCLES counter.
module pipeline_ctrl #(
  parameter int          DIV_CYCLES = 32,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [4:0]  EXC_NONE   = 5'h10,
  parameter logic [4:0]  EXC_ERET   = 5'h11
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        stallreq_id,
  input  logic        div_start,
  input  logic        div_ready,
  input  logic [4:0]  mem_exccode,
  input  logic [31:0] cp0_epc,
  output logic [3:0]  stall,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        div_busy,
  output logic        div_done,
  output logic        div_cancel
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DIV   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        exc, release_div;
  logic        cnt_load, cnt_dec, cnt_clr;
  logic [3:0]  stall_c;
  logic        flush_c, busy_c, done_c, cancel_c;
  logic [31:0] redirect;

  // Once in FLUSH the pipeline is empty, so any exccode there is stale.
  assign exc      = (mem_exccode != EXC_NONE) && ((state == RUN) || (state == DIV));
  assign redirect = (mem_exccode == EXC_ERET) ? cp0_epc : EXC_VECTOR;

`ifdef DIV_HANDSHAKE_EN
  localparam int unused_div_cycles = DIV_CYCLES;
  logic unused_cnt;

  assign release_div = div_ready;
  assign unused_cnt  = cnt_load ^ cnt_dec ^ cnt_clr;
`else
  localparam int CW = $clog2(DIV_CYCLES);
  logic [CW-1:0] count;
  logic          unused_div_ready;

  assign release_div      = (count == '0);
  assign unused_div_ready = div_ready;

  // Loaded with DIV_CYCLES-1 in the start cycle so the release lands DIV_CYCLES cycles later.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n)                   count <= '0;
    else if (cnt_clr)                 count <= '0;
    else if (cnt_load)                count <= CW'(DIV_CYCLES - 1);
    else if (cnt_dec && count != '0)  count <= count - CW'(1);
  end
`endif

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) state <= RUN;
    else            state <= state_next;
  end

  always_comb begin
    state_next = RUN;
    stall_c    = 4'b0000;
    flush_c    = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    cancel_c   = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      RUN: begin
        if (exc) begin
          flush_c    = 1'b1;
          cancel_c   = div_start;
          cnt_clr    = div_start;
          state_next = FLUSH;
        end else if (div_start) begin
          stall_c    = 4'b1111;
          cnt_load   = 1'b1;
          state_next = DIV;
        end else if (stallreq_id) begin
          stall_c    = 4'b0111;
        end
      end
      DIV: begin
        busy_c = 1'b1;
        if (exc) begin
          flush_c    = 1'b1;
          cancel_c   = 1'b1;
          cnt_clr    = 1'b1;
          state_next = FLUSH;
        end else if (release_div) begin
          done_c     = 1'b1;
          state_next = RUN;
        end else begin
          stall_c    = 4'b1111;
          cnt_dec    = 1'b1;
          state_next = DIV;
        end
      end
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Reset forces every output quiet regardless of the inputs presented.
  assign stall      = cpu_rst_n ? stall_c : 4'b0000;
  assign flush      = cpu_rst_n & flush_c;
  assign flush_pc   = (cpu_rst_n && flush_c) ? redirect : 32'd0;
  assign div_busy   = cpu_rst_n & busy_c;
  assign div_done   = cpu_rst_n & done_c;
  assign div_cancel = cpu_rst_n & cancel_c;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a divide-age reference model queues expected outputs,
// and a monitor process compares them a little after each falling edge.
module tb_pipeline_ctrl;

  localparam int          DIV_CYCLES = 4;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;
  localparam logic [4:0]  EXC_NONE   = 5'h10;
  localparam logic [4:0]  EXC_ERET   = 5'h11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stallreq_id = 1'b0;
  logic        div_start = 1'b0;
  logic        div_ready = 1'b0;
  logic [4:0]  mem_exccode = EXC_NONE;
  logic [31:0] cp0_epc = 32'd0;
  logic [3:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        div_busy, div_done, div_cancel;

  typedef struct {
    logic [3:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        busy;
    logic        done;
    logic        cancel;
    bit          check_pc;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cycle = 0;
  // div_age: 0 when no divide is in flight, else cycles elapsed since the start cycle.
  int   div_age = 0;
  bit   after_flush = 1'b0;

  pipeline_ctrl #(
    .DIV_CYCLES(DIV_CYCLES),
    .EXC_VECTOR(EXC_VECTOR),
    .EXC_NONE  (EXC_NONE),
    .EXC_ERET  (EXC_ERET)
  ) dut (
    .cpu_clk_50M(clk),
    .cpu_rst_n  (rst_n),
    .stallreq_id(stallreq_id),
    .div_start  (div_start),
    .div_ready  (div_ready),
    .mem_exccode(mem_exccode),
    .cp0_epc    (cp0_epc),
    .stall      (stall),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_cancel (div_cancel)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst, input logic sreq, input logic dstart,
                               input logic dready, input logic [4:0] code,
                               input logic [31:0] epc);
    exp_t e;
    bit   busy, exc, rel;
    @(negedge clk);
    rst_n = rst; stallreq_id = sreq; div_start = dstart; div_ready = dready;
    mem_exccode = code; cp0_epc = epc;
    e.stall = 4'b0000; e.flush = 1'b0; e.flush_pc = 32'd0; e.busy = 1'b0;
    e.done = 1'b0; e.cancel = 1'b0; e.check_pc = 1'b0; e.cyc = cycle;
    cycle++;
    if (!rst) begin
      e.check_pc  = 1'b1;
      div_age     = 0;
      after_flush = 1'b0;
    end else begin
      busy   = (div_age > 0);
      exc    = !after_flush && (code != EXC_NONE);
      e.busy = busy;
      if (exc) begin
        e.flush    = 1'b1;
        e.check_pc = 1'b1;
        e.flush_pc = (code == EXC_ERET) ? epc : EXC_VECTOR;
        e.cancel   = busy || dstart;
        div_age    = 0;
        after_flush = 1'b1;
      end else if (after_flush) begin
        after_flush = 1'b0;
      end else if (busy) begin
`ifdef DIV_HANDSHAKE_EN
        rel = dready;
`else
        rel = (div_age >= DIV_CYCLES);
`endif
        if (rel) begin
          e.done  = 1'b1;
          div_age = 0;
        end else begin
          e.stall = 4'b1111;
          div_age++;
        end
      end else if (dstart) begin
        e.stall = 4'b1111;
        div_age = 1;
      end else if (sreq) begin
        e.stall = 4'b0111;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want,
                        input int cyc);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    check1("stall",      {28'd0, stall},      {28'd0, e.stall},  e.cyc);
    check1("flush",      {31'd0, flush},      {31'd0, e.flush},  e.cyc);
    check1("div_busy",   {31'd0, div_busy},   {31'd0, e.busy},   e.cyc);
    check1("div_done",   {31'd0, div_done},   {31'd0, e.done},   e.cyc);
    check1("div_cancel", {31'd0, div_cancel}, {31'd0, e.cancel}, e.cyc);
    if (e.check_pc) check1("flush_pc", flush_pc, e.flush_pc, e.cyc);
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      checkOutput(e);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, EXC_NONE, 32'd0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, EXC_NONE, 32'd0);
    idle(1);
  endtask

  initial begin
    logic        r_rst, r_sreq, r_ds, r_dr;
    logic [4:0]  r_code;
    int          v;
    #1 rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, EXC_NONE, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'h08, 32'd0);
    idle(1);

    $display("[TB] reset asserted in the middle of a divide");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, EXC_NONE, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, EXC_NONE, 32'd0);
    idle(2);

    $display("[TB] back-to-back divides");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, EXC_NONE, 32'd0);
    idle(1);
    doReset();

    $display("[TB] load-use stall and its priority against a divide");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, EXC_NONE, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, EXC_NONE, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, EXC_NONE, 32'd0);
    doReset();

    $display("[TB] exception cancels a divide, then FLUSH ignores requests");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, EXC_NONE, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'h08, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'h08, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, EXC_NONE, 32'd0);

    $display("[TB] ERET redirect and a second exception in FLUSH");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, EXC_ERET, 32'h8000_0040);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'h04, 32'h8000_0040);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, EXC_NONE, 32'h8000_0040);
    doReset();

`ifdef DIV_HANDSHAKE_EN
    $display("[TB] divide released by div_ready after 7 stalled cycles");
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, EXC_NONE, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, EXC_NONE, 32'd0);
    idle(1);
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++) begin
      r_rst  = ($urandom_range(99) != 0);
      r_sreq = ($urandom_range(3) == 0);
      r_ds   = (div_age > 0) ? ($urandom_range(7) != 0) : ($urandom_range(5) == 0);
      r_dr   = ($urandom_range(4) == 0);
      v      = int'($urandom_range(15));
      r_code = (v == 0) ? EXC_ERET : (v == 1) ? 5'($urandom_range(31)) : EXC_NONE;
      applyStimulus(r_rst, r_sreq, r_ds, r_dr, r_code, $urandom);
    end

    @(negedge clk);
    #4;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
